// File: rtl/div_stall_unit_pkg.sv
// Shared encodings for the iterative RV32M divider.
// Holds the funct3/funct7 codes and FSM state type.
package div_stall_unit_pkg;

  localparam logic [1:0] FUNCT3_DIV  = 2'b00;
  localparam logic [1:0] FUNCT3_DIVU = 2'b01;
  localparam logic [1:0] FUNCT3_REM  = 2'b10;
  localparam logic [1:0] FUNCT3_REMU = 2'b11;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_CALC  = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  function automatic logic is_signed_op(
    input logic [1:0] f3
  );
    return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/div_stall_unit_if.sv
// EX-side handshake between pipeline and divider.
// master = pipeline/hazard side, slave = divider.
interface div_stall_unit_if #(
  parameter int XLEN = 32
);

  logic            start;
  logic [1:0]      funct3_lo;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            ex_busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3_lo, op_a, op_b, flush,
    input  ex_busy, done, result
  );

  modport slave (
    input  start, funct3_lo, op_a, op_b, flush,
    output ex_busy, done, result
  );

endinterface

// File: rtl/div_stall_unit_step.sv
// One restoring-division iteration, purely combinational.
// Shifts {rem,quo} left and trial-subtracts the divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, divisor_i};
    if (diff[XLEN]) begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_stall_unit.sv
// Iterative RV32M divider in EX; raises ex_busy while it runs.
// Flush aborts to IDLE; result only meaningful while done=1.
module div_stall_unit
  import div_stall_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  div_stall_unit_if.slave bus
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [1:0]       f3_q, f3_d;

  logic [XLEN-1:0]  step_rem;
  logic [XLEN-1:0]  step_quo;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             ovf;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    sgn    = is_signed_op(bus.funct3_lo);
    a_neg  = sgn & bus.op_a[XLEN-1];
    b_neg  = sgn & bus.op_b[XLEN-1];
    a_abs  = a_neg ? -bus.op_a : bus.op_a;
    b_abs  = b_neg ? -bus.op_b : bus.op_b;
    b_zero = (bus.op_b == '0);
    ovf    = sgn & (bus.op_a == SMIN) & (bus.op_b == '1);
    q_fix  = negq_q ? -quo_q : quo_q;
    r_fix  = negr_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    f3_d    = f3_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            b_zero: begin
              res_d   = bus.funct3_lo[1] ? bus.op_a : '1;
              state_d = DIV_DONE;
            end
            ovf: begin
              res_d   = bus.funct3_lo[1] ? '0 : SMIN;
              state_d = DIV_DONE;
            end
            default: begin
              quo_d   = a_abs;
              dvs_d   = b_abs;
              rem_d   = '0;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              f3_d    = bus.funct3_lo;
              cnt_d   = CNT_W'(XLEN-1);
              state_d = DIV_CALC;
            end
          endcase
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = DIV_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_FIXUP: begin
        res_d   = f3_q[1] ? r_fix : q_fix;
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    // a killed op never writes result and never reaches DONE
    if (bus.flush) begin
      state_d = DIV_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      f3_q    <= f3_d;
    end
  end

  assign bus.ex_busy = ((state_q == DIV_IDLE) & bus.start)
                     | (state_q == DIV_CALC)
                     | (state_q == DIV_FIXUP);
  assign bus.done    = (state_q == DIV_DONE);
  assign bus.result  = res_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit: latency, results, flush, reset.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_div_stall_unit;
  import div_stall_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  div_stall_unit_if #(.XLEN(32)) bus ();

  div_stall_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(
    input  logic [1:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          busy,
    output int          dcyc,
    output logic [31:0] res
  );
    busy = 0;
    dcyc = 0;
    res  = '0;
    bus.funct3_lo = f3;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.start     = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.ex_busy) busy++;
      if (bus.done) begin
        dcyc = c;
        res  = bus.result;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3_lo = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    total++;
    if (bus.ex_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", bus.ex_busy);
    end
    total++;
    if (bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_result got=%h want=0", bus.result);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    int busy, dcyc;
    logic [31:0] res;
    run_op(FUNCT3_DIVU, 32'd100, 32'd7, busy, dcyc, res);
    total++;
    if (busy !== 34) begin
      bad++;
      $display("FAIL divu_busy got=%0d want=34", busy);
    end
    total++;
    if (dcyc !== 35) begin
      bad++;
      $display("FAIL divu_latency got=%0d want=35", dcyc);
    end
    total++;
    if (res !== 32'd14) begin
      bad++;
      $display("FAIL divu_100_7 got=%h want=%h", res, 32'd14);
    end
    run_op(FUNCT3_REMU, 32'd100, 32'd7, busy, dcyc, res);
    total++;
    if (res !== 32'd2 || dcyc !== 35) begin
      bad++;
      $display("FAIL remu_100_7 got=%h@%0d want=2@35", res, dcyc);
    end
  endtask

  task automatic test_signed();
    int busy, dcyc;
    logic [31:0] res;
    run_op(FUNCT3_DIV, -32'sd7, 32'd2, busy, dcyc, res);
    total++;
    if (res !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_m7_2 got=%h want=fffffffd", res);
    end
    run_op(FUNCT3_REM, -32'sd7, 32'd2, busy, dcyc, res);
    total++;
    if (res !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL rem_m7_2 got=%h want=ffffffff", res);
    end
    run_op(FUNCT3_DIV, 32'd7, -32'sd2, busy, dcyc, res);
    total++;
    if (res !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_7_m2 got=%h want=fffffffd", res);
    end
    run_op(FUNCT3_REM, 32'd7, -32'sd2, busy, dcyc, res);
    total++;
    if (res !== 32'h0000_0001) begin
      bad++;
      $display("FAIL rem_7_m2 got=%h want=00000001", res);
    end
  endtask

  task automatic test_div_zero();
    int busy, dcyc;
    logic [31:0] res;
    run_op(FUNCT3_DIV, 32'd5, 32'd0, busy, dcyc, res);
    total++;
    if (res !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div_by0 got=%h want=ffffffff", res);
    end
    total++;
    if (dcyc !== 2 || busy !== 1) begin
      bad++;
      $display("FAIL div_by0_timing got=%0d/%0d want=2/1", dcyc, busy);
    end
    run_op(FUNCT3_REMU, 32'd5, 32'd0, busy, dcyc, res);
    total++;
    if (res !== 32'd5 || busy !== 1) begin
      bad++;
      $display("FAIL remu_by0 got=%h/%0d want=5/1", res, busy);
    end
  endtask

  task automatic test_overflow();
    int busy, dcyc;
    logic [31:0] res;
    run_op(FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, busy, dcyc, res);
    total++;
    if (res !== 32'h8000_0000 || dcyc !== 2) begin
      bad++;
      $display("FAIL div_ovf got=%h@%0d want=80000000@2", res, dcyc);
    end
    run_op(FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, busy, dcyc, res);
    total++;
    if (res !== 32'h0 || dcyc !== 2) begin
      bad++;
      $display("FAIL rem_ovf got=%h@%0d want=0@2", res, dcyc);
    end
  endtask

  task automatic test_flush();
    int busy, dcyc, seen;
    logic [31:0] res;
    bus.funct3_lo = FUNCT3_DIVU;
    bus.op_a      = 32'd1000;
    bus.op_b      = 32'd3;
    bus.start     = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (bus.ex_busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre_busy got=%b want=1", bus.ex_busy);
    end
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    total++;
    if (bus.ex_busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle got=%b%b want=00", bus.ex_busy, bus.done);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL flush_no_done got=%0d want=0", seen);
    end
    @(posedge clk);
    #1;
    run_op(FUNCT3_DIVU, 32'd9, 32'd3, busy, dcyc, res);
    total++;
    if (res !== 32'd3 || dcyc !== 35) begin
      bad++;
      $display("FAIL post_flush got=%h@%0d want=3@35", res, dcyc);
    end
  endtask

  task automatic test_reset_mid();
    bus.funct3_lo = FUNCT3_DIVU;
    bus.op_a      = 32'd77;
    bus.op_b      = 32'd5;
    bus.start     = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.ex_busy !== 1'b0 || bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid got=%b%b %h want=00 0",
               bus.done, bus.ex_busy, bus.result);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int busy, dcyc;
    logic [31:0] res;
    run_op(FUNCT3_DIVU, 32'd50, 32'd5, busy, dcyc, res);
    total++;
    if (res !== 32'd10 || dcyc !== 35) begin
      bad++;
      $display("FAIL b2b_0 got=%h@%0d want=a@35", res, dcyc);
    end
    run_op(FUNCT3_DIV, -32'sd20, 32'd3, busy, dcyc, res);
    total++;
    if (res !== 32'hFFFF_FFFA || dcyc !== 35) begin
      bad++;
      $display("FAIL b2b_1 got=%h@%0d want=fffffffa@35", res, dcyc);
    end
    run_op(FUNCT3_REM, -32'sd20, 32'd3, busy, dcyc, res);
    total++;
    if (res !== 32'hFFFF_FFFE || dcyc !== 35) begin
      bad++;
      $display("FAIL b2b_2 got=%h@%0d want=fffffffe@35", res, dcyc);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_stall_unit.md
Name: div_stall_unit

Overview:
- Iterative RV32M divider (DIV/DIVU/REM/REMU) that sits in EX beside the single-cycle ALU/multiplier.
- It is the stall *source* for the pipeline. While a division runs, it drives `ex_busy`, and hazard control turns that into `pc_en=0`, `if_id_pipeline_en=0` and an EX hold.
- It consumes the pipeline's flush so that a killed division aborts cleanly.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 4.
- CNT_W, 5, iteration counter width; equals $clog2(XLEN).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  EX holds a valid M-extension divide op (opcode R-type, funct7=0000001, funct3[2]=1).
- funct3_lo  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- op_a  input  XLEN  dividend (forwarded rs1 value).
- op_b  input  XLEN  divisor (forwarded rs2 value).
- flush  input  1  EX-stage kill (id_ex_pipeline_flush from hazard control).
- ex_busy  output  1  stall request to hazard control.
- done  output  1  one-cycle pulse; `result` valid this cycle.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, counter=0, internal registers=0, result=0, done=0. Reset overrides any operation in flight.
- States are IDLE, CALC, FIXUP, DONE.
- IDLE:
  - ex_busy = start (combinational), so the stall is asserted in the same cycle the op reaches EX.
  - Zero divisor, start=1: next state DONE; quotient = all ones; remainder = op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): next state DONE; quotient = 0x80000000; remainder = 0.
  - Otherwise, start=1: latch |op_a| and |op_b| (absolute only for signed ops), latch the sign flags and funct3_lo, clear the partial remainder, set counter = XLEN-1, go to CALC.
- CALC (exactly XLEN cycles):
  - Each cycle performs one restoring step: shift {rem,quo} left by one, trial-subtract the divisor from rem (XLEN+1-bit subtract), and on no borrow keep the difference and set quo[0]=1.
  - Counter decrements; when counter=0, go to FIXUP.
- FIXUP (1 cycle):
  - Quotient is negated if sign(a) XOR sign(b), signed ops only.
  - Remainder takes the sign of the dividend, signed ops only.
  - Select the quotient or the remainder by funct3_lo[1] and register it into `result`.
  - Next state DONE.
- DONE (1 cycle):
  - done=1 and ex_busy=0, so the pipeline advances at the end of this cycle.
  - start is ignored here: it is the same instruction still in EX.
  - Next state IDLE.
- ex_busy = (state==IDLE && start) || state==CALC || state==FIXUP.
- Latency: normal op is start cycle, then XLEN CALC cycles, then FIXUP, then DONE. For XLEN=32 that is 35 cycles from start to done, with ex_busy high for 34 cycles. Special cases: done in the cycle after start, ex_busy high for 1 cycle.
- Flush:
  - flush=1 in any state forces IDLE next cycle with done=0.
  - flush has priority over start and over normal transitions.
  - `result` holds its last value.
- Reset mid-CALC: IDLE next cycle, no done pulse.
- Operand stability: op_a/op_b are only sampled in IDLE, so forwarding changes during the stall are irrelevant.
- `result` is undefined except while done=1; the bench checks it only then.

Decomposition:
- defines.vh holds:
  - the funct3 encodings (FUNCT3_DIV/DIVU/REM/REMU)
  - FUNCT7_MULDIV
  - the state encodings (DIV_IDLE/CALC/FIXUP/DONE, 2 bits)
- One sub-module is natural: div_step, a combinational single restoring iteration (rem_in, quo_in, divisor -> rem_out, quo_out). It is instantiated once; the FSM and sign logic stay in div_stall_unit.
- Hazard control ORs ex_busy into the stall term; that edit lives in the hazard block, not here.

Test Plan:
- DIVU 100/7, start held → ex_busy high 34 cycles, done at cycle 35, result=14; repeat as REMU → result=2.
- DIV -7/2 → result=0xFFFFFFFD (-3); REM -7/2 → result=0xFFFFFFFF (-1); DIV 7/-2 → 0xFFFFFFFD.
- Divide by zero: DIV 5/0 → done the cycle after start, result=0xFFFFFFFF; REMU 5/0 → result=5; ex_busy high exactly 1 cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF → result=0x80000000; REM same operands → 0; done the cycle after start.
- Flush in CALC cycle 10 → IDLE next cycle, ex_busy=0, no done pulse; a fresh DIVU 9/3 started afterwards → result=3.
- rst_n=0 during CALC → all outputs 0 next cycle; back-to-back divides (start re-asserted the cycle after DONE) → each gets its own done pulse with the correct result.
